// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame data width, idle line level.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with push/pop, full/empty flags and an occupancy count.
// The head entry is read combinationally so a pop can load its consumer on the same edge.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [AW:0]      count_reg, count_next;
  logic             push_ok, pop_ok;

  // Flags come from the registered count, so a pop never frees space for a push on the same edge.
  assign full      = (count_reg == FULL_COUNT);
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/uart_buffered_transmitter.sv
// FIFO-buffered UART transmitter: bytes pushed over valid/ready are framed and sent LSB first on tx.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit after the data (11-bit frame);
// without it the frame is 8N1 (10 bits). Every bit lasts CLKS_PER_BIT clocks.
module uart_buffered_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [UART_DATA_BITS-1:0]     in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_tx_state_e              state_reg, state_next;
  logic [CW-1:0]               bit_cnt_reg;
  logic [2:0]                  bit_idx_reg;
  logic [UART_DATA_BITS-1:0]   shift_reg;
  logic                        tx_reg, tx_next;
  logic                        bit_tick;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_head;
`ifdef UART_TX_PARITY_EN
  logic                        parity_reg;
`endif

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign tx        = tx_reg;
  assign bit_tick  = (state_reg != IDLE) && (bit_cnt_reg == BIT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: each framed state advances on the bit-period terminal count.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (!fifo_empty) state_next = START;
      START:  if (bit_tick) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (bit_tick && bit_idx_reg == 3'd7) state_next = PARITY;
`else
      DATA:   if (bit_tick && bit_idx_reg == 3'd7) state_next = STOP;
`endif
      PARITY: if (bit_tick) state_next = STOP;
      STOP:   if (bit_tick) state_next = fifo_empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: pop decision, busy flag, and the line level for the bit about to start.
  always_comb begin
    busy     = (state_reg != IDLE);
    fifo_pop = ((state_reg == IDLE) || (state_reg == STOP && bit_tick)) && !fifo_empty;
    tx_next  = tx_reg;
    if (fifo_pop) begin
      tx_next = 1'b0;
    end else if (bit_tick) begin
      case (state_reg)
        START: tx_next = shift_reg[0];
        DATA: begin
          if (bit_idx_reg != 3'd7) tx_next = shift_reg[1];
`ifdef UART_TX_PARITY_EN
          else                     tx_next = parity_reg ^ shift_reg[0];
`else
          else                     tx_next = UART_IDLE_LEVEL;
`endif
        end
        default: tx_next = UART_IDLE_LEVEL;
      endcase
    end
  end

  // Datapath: line register, bit-period counter, bit index, shift register, parity accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_reg      <= UART_IDLE_LEVEL;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      tx_reg <= tx_next;
      if (fifo_pop) begin
        bit_cnt_reg <= '0;
        bit_idx_reg <= '0;
        shift_reg   <= fifo_head;
`ifdef UART_TX_PARITY_EN
        parity_reg  <= 1'b0;
`endif
      end else if (state_reg != IDLE) begin
        if (bit_tick) begin
          bit_cnt_reg <= '0;
          if (state_reg == DATA) begin
            // The bit leaving shift_reg[0] was on the line during this data bit.
            shift_reg   <= shift_reg >> 1;
            bit_idx_reg <= bit_idx_reg + 3'd1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_reg ^ shift_reg[0];
`endif
          end
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Directed bench for uart_buffered_transmitter with an independent serial decoder on tx.
module tb_uart_buffered_transmitter;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy;
  logic [3:0] fifo_count;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_buffered_transmitter #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Reference serial decoder: mid-bit sampling after the falling start edge.
  logic [7:0] dec_q[$];
  int         dec_err = 0;
  logic       dec_par = 1'b0;
  int         dec_active = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = 8'h00;
  int         cnt_max = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        dec_active = 0;
      end else begin
        if (int'(fifo_count) > cnt_max) cnt_max = int'(fifo_count);
        if (dec_active == 0) begin
          if (tx == 1'b0) begin
            dec_active = 1;
            dec_cnt = 0;
          end
        end else begin
          dec_cnt++;
          if (dec_cnt % CPB == CPB / 2) begin
            int k;
            k = dec_cnt / CPB;
            if (k == 0) begin
              if (tx !== 1'b0) begin
                dec_err++;
                dec_active = 0;
              end
            end else if (k <= 8) begin
              dec_byte[k-1] = tx;
            end else if (k < FRAME_BITS - 1) begin
              dec_par = tx;
            end else begin
              if (tx !== 1'b1) dec_err++;
`ifdef UART_TX_PARITY_EN
              else if (dec_par !== ^dec_byte) dec_err++;
`endif
              else begin
                dec_q.push_back(dec_byte);
                $display("[TB] rx byte 0x%02h at %0t", dec_byte, $time);
              end
              dec_active = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push_one(input logic [7:0] b);
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = !(busy || fifo_count != 0);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_state: tx=%b busy=%b in_ready=%b count=%0d, required 1 0 1 0", tx, busy, in_ready, fifo_count);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: tx=%b busy=%b, required 1 0", tx, busy);
    end
  endtask

  task automatic test_single_frame();
    int mism, nbusy, e0;
    dec_q.delete();
    e0 = dec_err;
    push_one(8'h55);
    tests_run++;
    if (fifo_count !== 4'd1 || tx !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_accept: count=%0d tx=%b busy=%b, required 1 1 0", fifo_count, tx, busy);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_start_edge: tx=%b busy=%b count=%0d, required 0 1 0", tx, busy, fifo_count);
    end
    mism = 0;
    nbusy = 0;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (tx !== frame_bit(8'h55, i / CPB)) mism++;
      if (busy) nbusy++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (mism != 0) begin
      tests_failed++;
      $display("FAIL single_waveform: %0d cycles wrong, required 0", mism);
    end
    tests_run++;
    if (nbusy != FRAME_CYC || busy !== 1'b0 || tx !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy: busy cycles=%0d end busy=%b tx=%b, required %0d 0 1", nbusy, busy, tx, FRAME_CYC);
    end
    tests_run++;
    if (dec_q.size() != 1 || dec_err != e0 || (dec_q.size() == 1 && dec_q[0] !== 8'h55)) begin
      tests_failed++;
      $display("FAIL single_decode: %0d bytes, first=0x%02h, errs=%0d, required 1 byte 0x55 no errors",
               dec_q.size(), (dec_q.size() > 0) ? dec_q[0] : 8'hxx, dec_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    int mism, nbusy, e0;
    logic [7:0] b;
    dec_q.delete();
    e0 = dec_err;
    in_data = 8'hA5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h3C;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (tx !== 1'b0 || fifo_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL b2b_start: tx=%b count=%0d, required 0 1", tx, fifo_count);
    end
    mism = 0;
    nbusy = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      b = (i < FRAME_CYC) ? 8'hA5 : 8'h3C;
      if (tx !== frame_bit(b, (i % FRAME_CYC) / CPB)) mism++;
      if (busy) nbusy++;
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (mism != 0 || nbusy != 2 * FRAME_CYC || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_waveform: wrong cycles=%0d busy cycles=%0d end busy=%b, required 0 %0d 0",
               mism, nbusy, busy, 2 * FRAME_CYC);
    end
    tests_run++;
    if (dec_q.size() != 2 || dec_err != e0 || (dec_q.size() == 2 && (dec_q[0] !== 8'hA5 || dec_q[1] !== 8'h3C))) begin
      tests_failed++;
      $display("FAIL b2b_decode: %0d bytes decoded, errs=%0d, required 0xA5 0x3C", dec_q.size(), dec_err - e0);
    end
  endtask

  task automatic test_fifo_full();
    int nxt, cyc, acc_cyc[10], e0, bad;
    logic rdy;
    bit ok;
    dec_q.delete();
    e0 = dec_err;
    cnt_max = 0;
    nxt = 0;
    cyc = 0;
    in_data = 8'h00;
    in_valid = 1'b1;
    while (nxt < 10 && cyc < FRAME_CYC + 50) begin
      rdy = in_ready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        acc_cyc[nxt] = cyc;
        nxt++;
      end
      #1;
      if (cyc == 9) begin
        tests_run++;
        if (in_ready !== 1'b0 || fifo_count !== 4'd8) begin
          tests_failed++;
          $display("FAIL full_flag: in_ready=%b count=%0d, required 0 8", in_ready, fifo_count);
        end
      end
      in_data = nxt[7:0];
      in_valid = (nxt < 10);
    end
    in_valid = 1'b0;
    tests_run++;
    if (nxt != 10 || acc_cyc[8] != 9 || acc_cyc[9] != FRAME_CYC + 3) begin
      tests_failed++;
      $display("FAIL full_accept_timing: accepted=%0d byte8 cycle=%0d byte9 cycle=%0d, required 10 9 %0d",
               nxt, acc_cyc[8], (nxt == 10) ? acc_cyc[9] : -1, FRAME_CYC + 3);
    end
    wait_idle(11 * FRAME_CYC, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL full_drain_timeout: busy=%b count=%0d, required idle", busy, fifo_count);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) if (i >= dec_q.size() || dec_q[i] !== 8'(i)) bad++;
    tests_run++;
    if (bad != 0 || dec_q.size() != 10 || dec_err != e0 || cnt_max != 8) begin
      tests_failed++;
      $display("FAIL full_decode: bytes=%0d wrong=%0d errs=%0d max count=%0d, required 10 0 0 8",
               dec_q.size(), bad, dec_err - e0, cnt_max);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] bytes [4];
    int e0;
    bit ok;
    bytes[0] = 8'h0F;
    bytes[1] = 8'h11;
    bytes[2] = 8'h22;
    bytes[3] = 8'h33;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = bytes[i];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (68) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || fifo_count !== 4'd3) begin
      tests_failed++;
      $display("FAIL midframe_before: busy=%b count=%0d, required 1 3", busy, fifo_count);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 4'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe_reset: tx=%b busy=%b count=%0d in_ready=%b, required 1 0 0 1",
               tx, busy, fifo_count, in_ready);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    dec_q.delete();
    e0 = dec_err;
    push_one(8'hC3);
    wait_idle(2 * FRAME_CYC, ok);
    tests_run++;
    if (!ok || dec_q.size() != 1 || dec_err != e0 || (dec_q.size() == 1 && dec_q[0] !== 8'hC3)) begin
      tests_failed++;
      $display("FAIL midframe_clean_frame: idle=%0d bytes=%0d errs=%0d, required idle and one 0xC3",
               ok, dec_q.size(), dec_err - e0);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [2];
    logic       par_exp [2];
    int nbusy;
    bytes[0] = 8'h07;
    par_exp[0] = 1'b1;
    bytes[1] = 8'h03;
    par_exp[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      dec_q.delete();
      push_one(bytes[j]);
      nbusy = 0;
      while (nbusy < 2 * FRAME_CYC && (busy || fifo_count != 0)) begin
        if (busy) nbusy++;
        @(posedge clk);
        #1;
      end
      tests_run++;
      if (nbusy != 176 || dec_par !== par_exp[j] || dec_q.size() != 1) begin
        tests_failed++;
        $display("FAIL parity_0x%02h: busy cycles=%0d parity=%b bytes=%0d, required 176 %b 1",
                 bytes[j], nbusy, dec_par, dec_q.size(), par_exp[j]);
      end
    end
  endtask
`endif

  task automatic test_random_stream();
    logic [7:0] exp_b [200];
    int idx, cyc, bad, e0;
    logic rdy;
    bit ok;
    for (int i = 0; i < 200; i++) exp_b[i] = 8'($urandom);
    dec_q.delete();
    e0 = dec_err;
    cnt_max = 0;
    idx = 0;
    cyc = 0;
    while (idx < 200 && cyc < 200 * FRAME_CYC + 1000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = exp_b[idx];
      rdy = in_ready;
      @(posedge clk);
      cyc++;
      if (in_valid && rdy) idx++;
      #1;
    end
    in_valid = 1'b0;
    wait_idle(10 * FRAME_CYC, ok);
    bad = 0;
    for (int i = 0; i < 200; i++) if (i >= dec_q.size() || dec_q[i] !== exp_b[i]) bad++;
    tests_run++;
    if (!ok || idx != 200 || dec_q.size() != 200 || bad != 0) begin
      tests_failed++;
      $display("FAIL random_stream: idle=%0d sent=%0d decoded=%0d wrong=%0d, required 1 200 200 0",
               ok, idx, dec_q.size(), bad);
    end
    tests_run++;
    if (dec_err != e0 || cnt_max > DEPTH) begin
      tests_failed++;
      $display("FAIL random_integrity: frame errs=%0d max count=%0d, required 0 and <= %0d",
               dec_err - e0, cnt_max, DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
